// File: rtl/onchip_mem_test_master_if.sv
// Avalon-MM bus between the memory test master and a single-port
// on-chip RAM slave.
//   m_address    word address
//   m_byteenable byte lanes (all ones during an access)
//   m_chipselect access valid
//   m_write      write strobe (0 = read)
//   m_writedata  write data
//   m_clken      RAM clock enable
//   m_readdata   RAM read data, READ_LATENCY cycles after the address
interface onchip_mem_test_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m_address;
    logic [DATA_W/8-1:0] m_byteenable;
    logic                m_chipselect;
    logic                m_write;
    logic [DATA_W-1:0]   m_writedata;
    logic                m_clken;
    logic [DATA_W-1:0]   m_readdata;

    modport master (
        output m_address, m_byteenable, m_chipselect, m_write,
               m_writedata, m_clken,
        input  m_readdata
    );

    modport slave (
        input  m_address, m_byteenable, m_chipselect, m_write,
               m_writedata, m_clken,
        output m_readdata
    );
endinterface

// File: rtl/onchip_mem_test_master.sv
// Memory test master: fills a RAM window with the pattern seed+i at
// address base_addr+i (wrapping at the top of RAM) and/or reads it back
// and checks it.
//   clk, reset   clock, synchronous active-high reset
//   start        one-cycle pulse, accepted only when idle
//   mode         00 fill, 01 verify, 10/11 fill then verify
//   base_addr    first word address
//   length       word count, 0..2**ADDR_W
//   seed         pattern seed
//   busy, done   operation in progress / completed (done holds)
//   error        sticky mismatch flag
//   err_addr     address of first mismatch
//   err_data     read data of first mismatch
//   err_count    saturating mismatch count
//   mem          Avalon-MM master port to the RAM
module onchip_mem_test_master #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 32,
    parameter int READ_LATENCY  = 1,
    parameter int STOP_ON_ERROR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W-1:0]   err_addr,
    output logic [DATA_W-1:0]   err_data,
    output logic [ADDR_W:0]     err_count,
    onchip_mem_test_master_if.master mem
);

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        VERIFY,
        DRAIN,
        DONE
    } state_t;

    state_t              state, state_n;

    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     len_q;
    logic [DATA_W-1:0]   seed_q;
    logic                verify_after_q;
    logic [ADDR_W:0]     idx;

    // Expected data/address for each outstanding read.
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [ADDR_W-1:0]       pipe_addr [READ_LATENCY];
    logic [DATA_W-1:0]       pipe_data [READ_LATENCY];

    logic                accept;
    logic                do_write;
    logic                do_read;
    logic                idx_inc;
    logic                idx_clr;
    logic                last;
    logic                mismatch;
    logic                halt;
    logic                pending;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_data;

    always_comb begin
        last     = (idx == len_q - ONE);
        cur_addr = base_q + idx[ADDR_W-1:0];
        cur_data = seed_q + DATA_W'(idx);
        mismatch = pipe_valid[READ_LATENCY-1] &&
                   (mem.m_readdata != pipe_data[READ_LATENCY-1]);
        // Issuing stops in the very cycle the mismatch is seen.
        halt     = (STOP_ON_ERROR != 0) && mismatch;
        // Reads still in flight beyond the stage compared this cycle.
        pending  = 1'b0;
        for (int unsigned i = 0; i + 1 < READ_LATENCY; i++) begin
            pending = pending | pipe_valid[i];
        end
    end

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        do_write = 1'b0;
        do_read  = 1'b0;
        idx_inc  = 1'b0;
        idx_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (length == '0)
                        state_n = DONE;
                    else if (mode == 2'b01)
                        state_n = VERIFY;
                    else
                        state_n = FILL;
                end
            end
            FILL: begin
                do_write = 1'b1;
                idx_inc  = 1'b1;
                if (last) begin
                    idx_clr = 1'b1;
                    state_n = verify_after_q ? VERIFY : DONE;
                end
            end
            VERIFY: begin
                if (halt) begin
                    state_n = DRAIN;
                end else begin
                    do_read = 1'b1;
                    idx_inc = 1'b1;
                    if (last)
                        state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (!pending)
                    state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        mem.m_chipselect = do_write | do_read;
        mem.m_write      = do_write;
        mem.m_address    = (do_write | do_read) ? cur_addr : '0;
        mem.m_writedata  = do_write ? cur_data : '0;
        mem.m_byteenable = (do_write | do_read) ? '1 : '0;
        mem.m_clken      = ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            base_q         <= '0;
            len_q          <= '0;
            seed_q         <= '0;
            verify_after_q <= 1'b0;
            idx            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_addr       <= '0;
            err_data       <= '0;
            err_count      <= '0;
            pipe_valid     <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_addr[i] <= '0;
                pipe_data[i] <= '0;
            end
        end else begin
            state <= state_n;

            if (accept) begin
                base_q         <= base_addr;
                len_q          <= length;
                seed_q         <= seed;
                verify_after_q <= mode[1];
                idx            <= '0;
                busy           <= 1'b1;
                done           <= 1'b0;
                error          <= 1'b0;
                err_addr       <= '0;
                err_data       <= '0;
                err_count      <= '0;
            end else if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + ONE;
            end

            if (state == DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end

            pipe_valid[0] <= do_read;
            pipe_addr[0]  <= cur_addr;
            pipe_data[0]  <= cur_data;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end

            if (mismatch) begin
                if (err_count != '1)
                    err_count <= err_count + ONE;
                if (!error) begin
                    error    <= 1'b1;
                    err_addr <= pipe_addr[READ_LATENCY-1];
                    err_data <= mem.m_readdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_onchip_mem_test_master.sv
module tb_onchip_mem_test_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start2;
    logic [1:0]  mode;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [31:0] seed;

    logic        busy1, done1, error1;
    logic [9:0]  err_addr1;
    logic [31:0] err_data1;
    logic [10:0] err_count1;
    logic        busy2, done2, error2;
    logic [9:0]  err_addr2;
    logic [31:0] err_data2;
    logic [10:0] err_count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    onchip_mem_test_master_if #(.ADDR_W(10), .DATA_W(32)) bus1 ();
    onchip_mem_test_master_if #(.ADDR_W(10), .DATA_W(32)) bus2 ();

    onchip_mem_test_master #(
        .ADDR_W(10), .DATA_W(32), .READ_LATENCY(1), .STOP_ON_ERROR(0)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode),
        .base_addr(base_addr), .length(length), .seed(seed),
        .busy(busy1), .done(done1), .error(error1), .err_addr(err_addr1),
        .err_data(err_data1), .err_count(err_count1), .mem(bus1)
    );

    onchip_mem_test_master #(
        .ADDR_W(10), .DATA_W(32), .READ_LATENCY(1), .STOP_ON_ERROR(1)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode),
        .base_addr(base_addr), .length(length), .seed(seed),
        .busy(busy2), .done(done2), .error(error2), .err_addr(err_addr2),
        .err_data(err_data2), .err_count(err_count2), .mem(bus2)
    );

    // RAM model for dut1, with one optional stuck word on the read side.
    logic [31:0] ram [1024];
    logic [31:0] rd1q = '0;
    logic        fault_en = 1'b0;
    logic [9:0]  fault_addr = '0;
    logic [31:0] fault_val = '0;

    always @(posedge clk) begin
        if (bus1.m_clken && bus1.m_chipselect) begin
            if (bus1.m_write)
                ram[bus1.m_address] <= bus1.m_writedata;
            else
                rd1q <= (fault_en && bus1.m_address == fault_addr) ? fault_val
                                                                   : ram[bus1.m_address];
        end
    end
    assign bus1.m_readdata = rd1q;

    // dut2 reads a window at 0x100 holding 0x5000+i, bad at i=2 and i=5.
    logic [31:0] rd2q = '0;
    always @(posedge clk) begin
        if (bus2.m_clken && bus2.m_chipselect && !bus2.m_write)
            rd2q <= (bus2.m_address == 10'h102 || bus2.m_address == 10'h105)
                    ? 32'hFFFF0000 : 32'h00005000 + 32'(bus2.m_address - 10'h100);
    end
    assign bus2.m_readdata = rd2q;

    // Bus logger, sampled on the falling edge.
    int          cyc = 0;
    int          wr_n = 0, rd_n = 0, rd2_n = 0;
    logic [9:0]  wr_addr [4096];
    logic [31:0] wr_data [4096];
    int          wr_cyc  [4096];
    logic [9:0]  rd_addr [4096];

    always @(negedge clk) begin
        cyc++;
        if (bus1.m_chipselect) begin
            if (bus1.m_write) begin
                if (wr_n < 4096) begin
                    wr_addr[wr_n] = bus1.m_address;
                    wr_data[wr_n] = bus1.m_writedata;
                    wr_cyc[wr_n]  = cyc;
                end
                wr_n++;
            end else begin
                if (rd_n < 4096)
                    rd_addr[rd_n] = bus1.m_address;
                rd_n++;
            end
        end
        if (bus2.m_chipselect && !bus2.m_write)
            rd2_n++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulses start on the chosen DUT and counts cycles until done is seen.
    // restart_at > 0 re-pulses start (with a different base) mid-operation.
    task automatic run_op(input int dut, input logic [1:0] md, input logic [9:0] b,
                          input logic [10:0] len, input logic [31:0] sd,
                          input int restart_at, output int cycles);
        logic d;
        @(negedge clk);
        mode = md; base_addr = b; length = len; seed = sd;
        start1 = (dut == 1);
        start2 = (dut == 2);
        cycles = 0;
        d = 1'b0;
        while (!d && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            start1 = (dut == 1) && (cycles == restart_at);
            start2 = 1'b0;
            if (cycles == restart_at)
                base_addr = 10'h300;
            d = (dut == 1) ? done1 : done2;
        end
    endtask

    initial begin
        int cycles;
        int w0, r0, r20;

        reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
        mode = 2'b00; base_addr = '0; length = '0; seed = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_error", error1, 0);
        check("rst_errcnt", err_count1, 0);
        check("rst_cs", bus1.m_chipselect, 0);
        check("rst_be", bus1.m_byteenable, 0);
        check("rst_clken", bus1.m_clken, 0);
        reset = 1'b0;
        @(negedge clk);
        check("clken_run", bus1.m_clken, 1);

        // Plain fill of 4 words at 0x010.
        w0 = wr_n; r0 = rd_n;
        run_op(1, 2'b00, 10'h010, 11'd4, 32'hA5A50000, 0, cycles);
        check("fill_cycles", cycles, 6);
        check("fill_nwr", wr_n - w0, 4);
        check("fill_nrd", rd_n - r0, 0);
        check("fill_a0", wr_addr[w0], 10'h010);
        check("fill_d0", wr_data[w0], 32'hA5A50000);
        check("fill_a3", wr_addr[w0+3], 10'h013);
        check("fill_d3", wr_data[w0+3], 32'hA5A50003);
        check("fill_b2b", wr_cyc[w0+3] - wr_cyc[w0], 3);
        check("fill_done", done1, 1);
        check("fill_busy", busy1, 0);
        check("fill_err", error1, 0);

        // Verify only, same window.
        w0 = wr_n; r0 = rd_n;
        run_op(1, 2'b01, 10'h010, 11'd4, 32'hA5A50000, 0, cycles);
        check("ver_cycles", cycles, 7);
        check("ver_nwr", wr_n - w0, 0);
        check("ver_nrd", rd_n - r0, 4);
        check("ver_err", error1, 0);
        check("ver_errcnt", err_count1, 0);

        // Full RAM fill then verify.
        w0 = wr_n; r0 = rd_n;
        run_op(1, 2'b10, 10'h000, 11'd1024, 32'h0, 0, cycles);
        check("full_cycles", cycles, 2051);
        check("full_nwr", wr_n - w0, 1024);
        check("full_nrd", rd_n - r0, 1024);
        check("full_errcnt", err_count1, 0);
        check("full_err", error1, 0);
        check("full_ram3ff", ram[10'h3FF], 32'h3FF);

        // Wrapping window with one stuck word at 0x001.
        fault_en = 1'b1; fault_addr = 10'h001; fault_val = 32'hDEADBEEF;
        w0 = wr_n; r0 = rd_n;
        run_op(1, 2'b10, 10'h3FE, 11'd4, 32'h11110000, 0, cycles);
        fault_en = 1'b0;
        check("wrap_cycles", cycles, 11);
        check("wrap_wa1", wr_addr[w0+1], 10'h3FF);
        check("wrap_wa2", wr_addr[w0+2], 10'h000);
        check("wrap_wd2", wr_data[w0+2], 32'h11110002);
        check("wrap_ra3", rd_addr[r0+3], 10'h001);
        check("wrap_err", error1, 1);
        check("wrap_erraddr", err_addr1, 10'h001);
        check("wrap_errdata", err_data1, 32'hDEADBEEF);
        check("wrap_errcnt", err_count1, 1);

        // Zero length: no bus cycles; start also clears previous status.
        w0 = wr_n; r0 = rd_n;
        run_op(1, 2'b10, 10'h055, 11'd0, 32'h1, 0, cycles);
        check("len0_cycles", cycles, 2);
        check("len0_bus", (wr_n - w0) + (rd_n - r0), 0);
        check("len0_err", error1, 0);
        check("len0_errcnt", err_count1, 0);

        // Start while busy is ignored.
        w0 = wr_n;
        run_op(1, 2'b00, 10'h020, 11'd6, 32'h100, 3, cycles);
        check("bsy_cycles", cycles, 8);
        check("bsy_nwr", wr_n - w0, 6);
        check("bsy_a3", wr_addr[w0+3], 10'h023);
        check("bsy_a5", wr_addr[w0+5], 10'h025);
        check("bsy_d5", wr_data[w0+5], 32'h105);

        // Reset in the middle of a fill.
        @(negedge clk);
        mode = 2'b00; base_addr = 10'h040; length = 11'd20; seed = '0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_cs_before", bus1.m_chipselect, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_busy", busy1, 0);
        check("mid_done", done1, 0);
        check("mid_cs", bus1.m_chipselect, 0);
        check("mid_wr", bus1.m_write, 0);
        check("mid_addr", bus1.m_address, 0);
        check("mid_wdata", bus1.m_writedata, 0);
        check("mid_clken", bus1.m_clken, 0);
        reset = 1'b0;
        w0 = wr_n;
        repeat (10) @(negedge clk);
        check("mid_nowr", wr_n - w0, 0);

        // Normal operation afterwards, mode 11 acts as fill then verify.
        w0 = wr_n; r0 = rd_n;
        run_op(1, 2'b11, 10'h050, 11'd2, 32'h7, 0, cycles);
        check("m11_cycles", cycles, 7);
        check("m11_nwr", wr_n - w0, 2);
        check("m11_nrd", rd_n - r0, 2);
        check("m11_err", error1, 0);
        check("m11_done", done1, 1);

        // Stop on first error: reads end after i=2.
        r20 = rd2_n;
        run_op(2, 2'b01, 10'h100, 11'd8, 32'h5000, 0, cycles);
        check("soe_cycles", cycles, 7);
        check("soe_nrd", rd2_n - r20, 3);
        check("soe_err", error2, 1);
        check("soe_erraddr", err_addr2, 10'h102);
        check("soe_errdata", err_data2, 32'hFFFF0000);
        check("soe_errcnt", err_count2, 1);
        check("soe_done", done2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
